// File: rtl/hazard_stall_controller_pkg.sv
// ============================================================================
// hazard_pkg : shared enums and default latencies for the hazard/stall block
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_LOAD_USE = 2'd1,
    CAUSE_COP0     = 2'd2,
    CAUSE_MULDIV   = 2'd3
  } stall_cause_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam int DEF_MUL_CYCLES = 4;
  localparam int DEF_DIV_CYCLES = 33;
  localparam int DEF_CNT_W      = 32;

endpackage

`default_nettype wire

// File: rtl/hazard_stall_controller_if.sv
// ============================================================================
// hazard_stall_controller_if : decode/execute hazard inputs and stall outputs
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_controller_if #(
  parameter int CNT_W = 32
);
  logic             d_valid;
  logic [4:0]       d_rs;
  logic [4:0]       d_rt;
  logic             d_use_rs;
  logic             d_use_rt;
  logic             d_use_hilo;
  logic             d_use_cop0;
  logic             e_valid;
  logic [4:0]       e_dest;
  logic             e_write_reg;
  logic             e_is_load;
  logic             e_write_cop0;
  logic             md_start;
  logic             md_is_div;
  logic             flush;
  logic             stall_f;
  logic             stall_d;
  logic             bubble_e;
  logic [1:0]       stall_cause;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] perf_stall_cnt;

  modport master (
    output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_use_hilo, d_use_cop0,
    output e_valid, e_dest, e_write_reg, e_is_load, e_write_cop0,
    output md_start, md_is_div, flush,
    input  stall_f, stall_d, bubble_e, stall_cause, md_busy, md_done,
    input  perf_stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_use_hilo, d_use_cop0,
    input  e_valid, e_dest, e_write_reg, e_is_load, e_write_cop0,
    input  md_start, md_is_div, flush,
    output stall_f, stall_d, bubble_e, stall_cause, md_busy, md_done,
    output perf_stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_controller_md_busy_tracker.sv
// ============================================================================
// md_busy_tracker : mul/div occupancy FSM with down-counter, registered outputs
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  start,
  input  wire  is_div,
  input  wire  flush,
  output logic busy,
  output logic done
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  md_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          w_launch;
  logic [CW-1:0] w_load;

  assign w_launch = start && !flush;
  assign w_load   = is_div ? DIV_LOAD : MUL_LOAD;

  // Counter holds remaining BUSY cycles; leaving at cnt==1 puts DONE exactly N cycles after start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE, MD_DONE: begin
          if (w_launch) begin
            cnt_q <= w_load;
            if (w_load == '0) begin
              state_q <= MD_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= MD_BUSY;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        MD_BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q <= CW'(1)) begin
            state_q <= MD_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!rst_n) !(w_launch && state_q == MD_BUSY)
  );

endmodule

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
// ============================================================================
// hazard_stall_controller : load-use / COP0 / HI-LO stall generation + perf count
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input wire clk,
  input wire rst_n,
  hazard_stall_controller_if.slave bus
);

  logic             w_rs_hit;
  logic             w_rt_hit;
  logic             w_load_use;
  logic             w_cop0_h;
  logic             w_md_h;
  logic             w_stall;
  logic             w_md_busy;
  logic             w_md_done;
  stall_cause_t     w_cause;
  logic [CNT_W-1:0] perf_q;
  logic [CNT_W-1:0] perf_d;

  md_busy_tracker #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_tracker (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (bus.md_start),
    .is_div (bus.md_is_div),
    .flush  (bus.flush),
    .busy   (w_md_busy),
    .done   (w_md_done)
  );

  always_comb begin
    w_rs_hit   = bus.d_use_rs && (bus.d_rs == bus.e_dest);
    w_rt_hit   = bus.d_use_rt && (bus.d_rt == bus.e_dest);
    w_load_use = bus.d_valid && bus.e_valid && bus.e_is_load && bus.e_write_reg
                 && (bus.e_dest != 5'd0) && (w_rs_hit || w_rt_hit);
    w_cop0_h   = bus.d_valid && bus.e_valid && bus.e_write_cop0 && bus.d_use_cop0;
    // A mul/div launched this cycle is already visible to a HI/LO reader in decode.
    w_md_h     = bus.d_valid && bus.d_use_hilo
                 && (w_md_busy || (bus.md_start && !bus.flush));
    w_cause    = CAUSE_NONE;
    if (!bus.flush) begin
      if (w_load_use) begin
        w_cause = CAUSE_LOAD_USE;
      end else if (w_cop0_h) begin
        w_cause = CAUSE_COP0;
      end else if (w_md_h) begin
        w_cause = CAUSE_MULDIV;
      end
    end
    w_stall = (w_cause != CAUSE_NONE);
  end

  always_comb begin
    perf_d = perf_q;
    if (w_stall && (perf_q != {CNT_W{1'b1}})) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign bus.stall_f        = w_stall;
  assign bus.stall_d        = w_stall;
  assign bus.bubble_e       = w_stall;
  assign bus.stall_cause    = w_cause;
  assign bus.md_busy        = w_md_busy;
  assign bus.md_done        = w_md_done;
  assign bus.perf_stall_cnt = perf_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// ============================================================================
// tb_hazard_stall_controller : directed vectors with queue-based scoreboard
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_controller;
  import hazard_pkg::*;

  localparam int TB_CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_controller_if #(.CNT_W(TB_CNT_W)) bus();

  hazard_stall_controller #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (33),
    .CNT_W      (TB_CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         id;
    logic       stall;
    logic [1:0] cause;
    logic       busy;
    logic       done;
    logic [3:0] perf;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   vid   = 0;

  exp_t       m_e;
  logic [9:0] m_act;
  logic [9:0] m_exp;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e   = exp_q.pop_front();
      m_act = {bus.stall_f, bus.stall_d, bus.bubble_e, bus.stall_cause,
               bus.md_busy, bus.md_done, bus.perf_stall_cnt};
      m_exp = {m_e.stall, m_e.stall, m_e.stall, m_e.cause,
               m_e.busy, m_e.done, m_e.perf};
      n_vec++;
      if (m_act !== m_exp) begin
        n_bad++;
        $display("FAIL vec%0d {sf,sd,be,cause,busy,done,perf}: got %b expected %b",
                 m_e.id, m_act, m_exp);
      end
    end
  end

  task automatic clr();
    bus.d_valid      = 1'b0;
    bus.d_rs         = 5'd0;
    bus.d_rt         = 5'd0;
    bus.d_use_rs     = 1'b0;
    bus.d_use_rt     = 1'b0;
    bus.d_use_hilo   = 1'b0;
    bus.d_use_cop0   = 1'b0;
    bus.e_valid      = 1'b0;
    bus.e_dest       = 5'd0;
    bus.e_write_reg  = 1'b0;
    bus.e_is_load    = 1'b0;
    bus.e_write_cop0 = 1'b0;
    bus.md_start     = 1'b0;
    bus.md_is_div    = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic step(input logic s, input logic [1:0] c, input logic b,
                      input logic d, input logic [3:0] p);
    exp_t e;
    e.id = vid; e.stall = s; e.cause = c; e.busy = b; e.done = d; e.perf = p;
    vid++;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cop0_pair();
    bus.d_valid      = 1'b1;
    bus.e_valid      = 1'b1;
    bus.e_write_cop0 = 1'b1;
    bus.d_use_cop0   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;
    step(1'b0, 2'd0, 1'b0, 1'b0, 4'd0);

    // load-use on rs, then bubbled E, then r0 and unused-rs cases
    bus.d_valid = 1'b1; bus.e_valid = 1'b1; bus.e_is_load = 1'b1; bus.e_write_reg = 1'b1;
    bus.e_dest = 5'd5; bus.d_use_rs = 1'b1; bus.d_rs = 5'd5;
    step(1'b1, 2'd1, 1'b0, 1'b0, 4'd0);
    bus.e_valid = 1'b0;
    step(1'b0, 2'd0, 1'b0, 1'b0, 4'd1);
    bus.e_valid = 1'b1; bus.e_dest = 5'd0; bus.d_rs = 5'd0;
    step(1'b0, 2'd0, 1'b0, 1'b0, 4'd1);
    bus.e_dest = 5'd5; bus.d_rs = 5'd5; bus.d_use_rs = 1'b0;
    step(1'b0, 2'd0, 1'b0, 1'b0, 4'd1);
    bus.d_use_rt = 1'b1; bus.d_rt = 5'd7; bus.e_dest = 5'd7;
    step(1'b1, 2'd1, 1'b0, 1'b0, 4'd1);

    // cop0 alone, cop0 + load-use, cop0 under flush
    clr(); cop0_pair();
    step(1'b1, 2'd2, 1'b0, 1'b0, 4'd2);
    bus.e_is_load = 1'b1; bus.e_write_reg = 1'b1; bus.e_dest = 5'd3;
    bus.d_use_rs = 1'b1; bus.d_rs = 5'd3;
    step(1'b1, 2'd1, 1'b0, 1'b0, 4'd3);
    bus.flush = 1'b1;
    step(1'b0, 2'd0, 1'b0, 1'b0, 4'd4);

    // multiply: busy t+1..t+3, done t+4, mflo stalls t+2..t+3
    clr(); bus.md_start = 1'b1;
    step(1'b0, 2'd0, 1'b0, 1'b0, 4'd4);
    clr();
    step(1'b0, 2'd0, 1'b1, 1'b0, 4'd4);
    bus.d_valid = 1'b1; bus.d_use_hilo = 1'b1;
    step(1'b1, 2'd3, 1'b1, 1'b0, 4'd4);
    step(1'b1, 2'd3, 1'b1, 1'b0, 4'd5);
    step(1'b0, 2'd0, 1'b0, 1'b1, 4'd6);
    clr();
    step(1'b0, 2'd0, 1'b0, 1'b0, 4'd6);

    // divide launched under flush is discarded
    bus.d_valid = 1'b1; bus.d_use_hilo = 1'b1; bus.md_start = 1'b1;
    bus.md_is_div = 1'b1; bus.flush = 1'b1;
    step(1'b0, 2'd0, 1'b0, 1'b0, 4'd6);
    clr();
    for (int i = 0; i < 34; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 4'd6);

    // divide with a HI/LO reader in the launch cycle, flush at t+10, back-to-back mul at done
    bus.md_start = 1'b1; bus.md_is_div = 1'b1; bus.d_valid = 1'b1; bus.d_use_hilo = 1'b1;
    step(1'b1, 2'd3, 1'b0, 1'b0, 4'd6);
    for (int k = 1; k <= 33; k++) begin
      clr();
      if (k == 5)  begin bus.d_valid = 1'b1; bus.d_use_hilo = 1'b1; end
      if (k == 10) bus.flush = 1'b1;
      if (k == 33) begin bus.md_start = 1'b1; bus.md_is_div = 1'b0; end
      step(k == 5, 2'((k == 5) ? 3 : 0), k <= 32, k == 33, 4'((k <= 5) ? 7 : 8));
    end
    clr();
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1, 1'b0, 4'd8);
    step(1'b0, 2'd0, 1'b0, 1'b1, 4'd8);

    // saturation of the 4-bit perf counter
    clr(); cop0_pair();
    for (int i = 0; i < 20; i++) step(1'b1, 2'd2, 1'b0, 1'b0, 4'(((8 + i) > 15) ? 15 : (8 + i)));
    clr();
    step(1'b0, 2'd0, 1'b0, 1'b0, 4'd15);

    // asynchronous reset in the middle of a divide
    bus.md_start = 1'b1; bus.md_is_div = 1'b1;
    step(1'b0, 2'd0, 1'b0, 1'b0, 4'd15);
    clr();
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1, 1'b0, 4'd15);
    rst_n = 1'b0;
    step(1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 36; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 4'd0);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Covers the hazards that operand forwarding cannot resolve, and generates stall/bubble control for the fetch, decode and execute stages.
- Detects three cases:
  - a load-use dependency on a load sitting in execute;
  - a COP0 read (mfc0/eret) in decode that follows an mtc0 in execute;
  - HI/LO access while the iterative multiply/divide unit is busy.
- Tracks multiply/divide occupancy with a small FSM and counter, and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
MUL_CYCLES, 4, cycles from md_start to md_done for mult/multu
DIV_CYCLES, 33, cycles from md_start to md_done for div/divu
CNT_W, 32, width of perf stall counter

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
d_valid  input  1  decode stage holds a real instruction
d_rs  input  5  decode rs index
d_rt  input  5  decode rt index
d_use_rs  input  1  decode instruction reads rs
d_use_rt  input  1  decode instruction reads rt
d_use_hilo  input  1  decode reads/writes HI/LO or is a mul/div op
d_use_cop0  input  1  decode reads a COP0 register (mfc0, eret)
e_valid  input  1  execute stage holds a real instruction
e_dest  input  5  execute destination register
e_write_reg  input  1  execute writes the GPR file
e_is_load  input  1  execute instruction is a load
e_write_cop0  input  1  execute instruction is mtc0
md_start  input  1  execute issues a mul/div this cycle
md_is_div  input  1  qualifies md_start: 1=div, 0=mul
flush  input  1  exception/redirect flush of F/D/E
stall_f  output  1  hold PC
stall_d  output  1  hold decode register
bubble_e  output  1  load a NOP into execute next cycle
stall_cause  output  2  0 none, 1 load-use, 2 cop0, 3 muldiv
md_busy  output  1  mul/div in progress
md_done  output  1  one-cycle pulse; HI/LO result valid
perf_stall_cnt  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (async, rst_n=0): md FSM=IDLE, counter=0, perf_stall_cnt=0. All outputs are 0.
- Hazard terms:
  - load_use = d_valid & e_valid & e_is_load & e_write_reg & e_dest!=0 & ((d_use_rs & d_rs==e_dest) | (d_use_rt & d_rt==e_dest)).
  - cop0_h = d_valid & e_valid & e_write_cop0 & d_use_cop0. This is a conservative match on any COP0 register.
  - md_h = d_valid & d_use_hilo & md_busy_next_visible. md_busy_next_visible = md_busy, or md_start this cycle with flush=0.
- Priority: load-use > cop0 > muldiv. stall_cause reports the highest-priority active term.
- stall = load_use|cop0_h|md_h. Outputs stall_f=stall_d=bubble_e=stall.
- All stall outputs are combinational from the current inputs and state.
- flush=1 forces stall_f, stall_d, bubble_e and stall_cause to 0, so the redirect always proceeds.
- MD FSM states IDLE, BUSY, DONE:
  - IDLE: md_start & !flush → BUSY. Counter is loaded with (md_is_div ? DIV_CYCLES : MUL_CYCLES) - 1.
  - BUSY: decrement each cycle. At counter==0 → DONE.
  - DONE: md_done=1 for one cycle. Then:
    - md_start & !flush → BUSY, reloaded as above;
    - otherwise → IDLE.
  - md_busy=1 in BUSY. md_busy=0 in IDLE and DONE.
  - A HI/LO reader in decode during DONE does not stall, because the result is forwarded through the normal path.
- Latency: md_done asserts exactly N cycles after the md_start cycle (N=MUL_CYCLES or DIV_CYCLES).
- md_start while BUSY is a protocol violation: md_h prevents it from occurring. It is ignored, and a simulation assertion fires.
- Flush:
  - md_start in the same cycle as flush is discarded.
  - An operation already in BUSY continues to completion. It is an older, committed instruction.
- perf_stall_cnt increments on each cycle with stall=1 & flush=0. It saturates at all-ones.
- Reset mid-operation: FSM returns to IDLE immediately. No md_done pulse is produced.
- Register 0 never causes a load-use stall.

Decomposition:
- Package hazard_pkg holds:
  - stall_cause_t enum (NONE, LOAD_USE, COP0, MULDIV);
  - md_state_t enum (IDLE, BUSY, DONE);
  - default latency constants.
- Sub-module md_busy_tracker contains the FSM and down-counter. Ports: clk, rst_n, start, is_div, flush, busy, done.
- The top level holds the comparators, priority logic and perf counter.

Test Plan:
- lw writes r5 in E (e_is_load=1, e_dest=5), decode add reads rs=5 → stall=1 for one cycle, stall_cause=1. The next cycle, with E bubbled, stall=0.
- Same as above with e_dest=0 and d_rs=0 → no stall. With d_use_rs=0 → no stall.
- mtc0 in E (e_write_cop0=1), eret in D (d_use_cop0=1) → stall_cause=2 for one cycle. If load_use is also true, stall_cause=1.
- md_start, md_is_div=0 at cycle t → md_busy during t+1..t+3, md_done at t+4. mflo in D at t+2 → stall until t+4, released at t+4.
- div at t with flush=1 in the same cycle → FSM stays IDLE, no md_done. div at t without flush → md_done at t+33. flush at t+10 → busy persists, md_done still at t+33.
- Hold stall=1 with CNT_W=4 for 20 cycles → perf_stall_cnt saturates at 15. rst_n low mid-division → md_busy=0 and perf_stall_cnt=0 immediately, asynchronously.
